b01_serial_sched: RTL

- Scheduler that shares one b01-style serial comparator between two requesters.
- Each requester presents a pair of W-bit operands. The block grants one requester round-robin and serialises its operand pair LSB-first onto LINE1/LINE2.
- It collects the unit's registered OUTP stream into a W-bit result and flags any OVERFLW seen during the transfer.
- Sits between the requesters and the serial unit. It is the only driver of that unit's inputs.

---
 rtl/b01_serial_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/b01_serial_sched.sv
// -----------------------------------------------------------------------------
// b01_serial_sched
//
// Shares one b01-style serial comparator between two requesters. A requester
// is granted round-robin, its operand pair is latched and shifted LSB-first
// onto line1/line2, and the unit's registered outp stream is collected back
// into a W-bit result. Any overflw seen during the capture window is flagged.
//
// Ports
//   clock          rising-edge clock for all state
//   reset          synchronous, active-high; dominates everything
//   req0/req1      requests, held until the matching ack
//   a0,b0 / a1,b1  W-bit operands (LINE1 / LINE2), sampled only at grant
//   ack0/ack1      one-cycle completion pulses, never high together
//   res            captured outp word of the last completed job
//   ovf            overflw seen during the last job's capture window
//   line1/line2    serial bits into the unit; 0 outside SHIFT
//   outp/overflw   the unit's registered outputs
//   busy           high in every state except IDLE
// -----------------------------------------------------------------------------
module b01_serial_sched #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] res,
    output logic         ovf,
    output logic         line1,
    output logic         line2,
    input  logic         outp,
    input  logic         overflw,
    output logic         busy
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ptr;     // id of the last granted requester
    logic          r_gnt;     // id of the job in flight
    logic [W-1:0]  r_sa;
    logic [W-1:0]  r_sb;
    logic [W-1:0]  r_res;
    logic          r_ovf;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_line1;
    logic          r_line2;

    logic          w_req_any;
    logic          w_gid;
    logic [W-1:0]  w_a;
    logic [W-1:0]  w_b;
    logic          w_last;

    assign w_req_any = req0 | req1;
    // Tie goes to the requester that was not granted last; otherwise the
    // lone requester wins (req0 alone -> 0, req1 alone -> 1).
    assign w_gid     = (req0 & req1) ? ~r_ptr : req1;
    assign w_a       = w_gid ? a1 : a0;
    assign w_b       = w_gid ? b1 : b0;
    assign w_last    = (r_cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= 1'b1;
            r_gnt   <= 1'b0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_ovf   <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_line1 <= 1'b0;
            r_line2 <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state <= S_SHIFT;
                        r_ptr   <= w_gid;
                        r_gnt   <= w_gid;
                        r_sa    <= w_a;
                        r_sb    <= w_b;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_ovf   <= 1'b0;
                        // Bit 0 goes out with the grant so it is on the
                        // pins during the first SHIFT cycle.
                        r_line1 <= w_a[0];
                        r_line2 <= w_b[0];
                    end
                end
                S_SHIFT: begin
                    // outp lags the pins by one cycle, so the bit seen now
                    // belongs to the previous count.
                    if (r_cnt != '0) begin
                        r_res[r_cnt - 1'b1] <= outp;
                        r_ovf               <= r_ovf | overflw;
                    end
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_line1 <= 1'b0;
                        r_line2 <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_sa    <= r_sa >> 1;
                        r_sb    <= r_sb >> 1;
                        r_line1 <= r_sa[1];
                        r_line2 <= r_sb[1];
                    end
                end
                S_DRAIN: begin
                    // Last result bit arrives one cycle after the last
                    // operand bit left.
                    r_res[W-1] <= outp;
                    r_ovf      <= r_ovf | overflw;
                    r_state    <= S_RESP;
                    if (r_gnt) r_ack1 <= 1'b1;
                    else       r_ack0 <= 1'b1;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_line1 <= 1'b0;
                    r_line2 <= 1'b0;
                end
            endcase
        end
    end

    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign res   = r_res;
    assign ovf   = r_ovf;
    assign line1 = r_line1;
    assign line2 = r_line2;
    assign busy  = (r_state != S_IDLE);

endmodule
